// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    ISSUE = 3'd4
  } cmd_state_t;

  typedef enum logic [1:0] {
    CSUM_ERR = 2'd0,
    OVR_ERR  = 2'd1,
    TMO_ERR  = 2'd2
  } err_cause_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic logic [7:0] calc_csum(input logic [7:0] sync_b,
                                           input logic [7:0] addr_b,
                                           input logic [7:0] data_b);
    return sync_b ^ addr_b ^ data_b;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Register-write request channel: valid/ready with address and data.
interface uart_cmd_wr_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_rdy_sync.sv
// Synchronizes the receiver byte-ready level and emits a registered one-cycle
// strobe on its rising edge (SYNC_STAGES+1 cycles after rx_rdy rises).
module uart_rdy_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic rx_rdy_i,
  output logic byte_stb_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   stb_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_rdy_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      stb_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign byte_stb_o = stb_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame sequencer SYNC,ADDR,DATA,CSUM -> one register write per good frame.
// Inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
//
// state | meaning
// HUNT  | waiting for the sync byte
// ADDR  | next byte is the register address
// DATA  | next byte is the write data
// CSUM  | next byte is the checksum
// ISSUE | write request pending on wr
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  uart_cmd_wr_if.master       wr,
  output logic                busy,
  output logic [7:0]          pkt_ok_cnt,
  output logic [7:0]          err_cnt,
  output logic                err_pulse
);

  cmd_state_t state_q;
  logic [7:0] addr_q, data_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic       wr_valid_q;
  logic [7:0] ok_q, err_q;
  logic       err_pulse_q;
  logic       byte_stb;
  logic       tmo_hit;
  logic [2:0] err_vec;
  logic       err_any;

  uart_rdy_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk       (clk),
    .rst_l     (rst_l),
    .rx_rdy_i  (rx_rdy),
    .byte_stb_o(byte_stb)
  );

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        in_frame;

  assign in_frame = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
  assign tmo_hit  = in_frame && (tmo_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                     tmo_q <= '0;
    else if (byte_stb || !in_frame) tmo_q <= '0;
    else                            tmo_q <= tmo_q + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    err_vec           = '0;
    err_vec[CSUM_ERR] = (state_q == CSUM) && byte_stb &&
                        (rx_data != calc_csum(SYNC_BYTE, addr_q, data_q));
    err_vec[OVR_ERR]  = (state_q == ISSUE) && byte_stb;
    // a byte arriving on the timeout cycle rescues the frame
    err_vec[TMO_ERR]  = tmo_hit && !byte_stb;
    err_any           = |err_vec;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= HUNT;
      addr_q      <= '0;
      data_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      ok_q        <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= err_any;
      if (err_any && err_q != 8'hFF) err_q <= err_q + 8'd1;
      case (state_q)
        HUNT: if (byte_stb && rx_data == SYNC_BYTE) state_q <= ADDR;
        ADDR: begin
          if (byte_stb) begin
            addr_q  <= rx_data;
            state_q <= DATA;
          end else if (tmo_hit) state_q <= HUNT;
        end
        DATA: begin
          if (byte_stb) begin
            data_q  <= rx_data;
            state_q <= CSUM;
          end else if (tmo_hit) state_q <= HUNT;
        end
        CSUM: begin
          if (byte_stb) begin
            if (rx_data == calc_csum(SYNC_BYTE, addr_q, data_q)) begin
              wr_addr_q  <= addr_q;
              wr_data_q  <= data_q;
              wr_valid_q <= 1'b1;
              state_q    <= ISSUE;
            end else state_q <= HUNT;
          end else if (tmo_hit) state_q <= HUNT;
        end
        ISSUE: begin
          if (wr_valid_q && wr.wr_ready) begin
            wr_valid_q <= 1'b0;
            if (ok_q != 8'hFF) ok_q <= ok_q + 8'd1;
            state_q    <= HUNT;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign busy        = (state_q != HUNT);
  assign pkt_ok_cnt  = ok_q;
  assign err_cnt     = err_q;
  assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl; expected writes are queued as frames are sent.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy, err_pulse;
  logic [7:0] pkt_ok_cnt, err_cnt;

  uart_cmd_wr_if wr_bus();

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .wr        (wr_bus.master),
    .busy      (busy),
    .pkt_ok_cnt(pkt_ok_cnt),
    .err_cnt   (err_cnt),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int errp_cycles = 0;
  int valid_cycles = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_a = 8'h00, prev_d = 8'h00;
  logic [7:0] exp_ok = 8'd0, exp_err = 8'd0;

  // Output monitor: pops the scoreboard on every handshake, checks hold stability.
  always @(negedge clk) begin
    wr_t e;
    if (rst_l) begin
      if (wr_bus.wr_valid) valid_cycles++;
      if (err_pulse) errp_cycles++;
      if (wr_bus.wr_valid && prev_valid && !prev_hs) begin
        total++;
        if ({wr_bus.wr_addr, wr_bus.wr_data} !== {prev_a, prev_d}) begin
          bad++;
          $display("FAIL hold_stable: got %h/%h expected %h/%h",
                   wr_bus.wr_addr, wr_bus.wr_data, prev_a, prev_d);
        end
      end
      if (wr_bus.wr_valid && wr_bus.wr_ready) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got %h/%h expected none",
                   wr_bus.wr_addr, wr_bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_bus.wr_addr, wr_bus.wr_data} !== {e.a, e.d}) begin
            bad++;
            $display("FAIL write_payload: got %h/%h expected %h/%h",
                     wr_bus.wr_addr, wr_bus.wr_data, e.a, e.d);
          end
        end
      end
      prev_valid = wr_bus.wr_valid;
      prev_hs    = wr_bus.wr_valid && wr_bus.wr_ready;
      prev_a     = wr_bus.wr_addr;
      prev_d     = wr_bus.wr_data;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick(6);
    rx_rdy  = 1'b0;
    tick(4);
  endtask

  // Queues the expected write when the model checksum matches.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] cs);
    wr_t w;
    if (cs == (8'hA5 ^ a ^ d)) begin
      w.a = a; w.d = d;
      exp_q.push_back(w);
    end
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(cs);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    wr_bus.wr_ready = 1'b1;
    tick(3);
    total++; if (wr_bus.wr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", wr_bus.wr_valid); end
    total++; if ({wr_bus.wr_addr, wr_bus.wr_data} !== 16'h0000) begin bad++; $display("FAIL reset_addr_data: got %h%h expected 0000", wr_bus.wr_addr, wr_bus.wr_data); end
    total++; if ({busy, err_pulse} !== 2'b00) begin bad++; $display("FAIL reset_busy_pulse: got %b%b expected 00", busy, err_pulse); end
    total++; if ({pkt_ok_cnt, err_cnt} !== 16'h0000) begin bad++; $display("FAIL reset_counts: got %h/%h expected 00/00", pkt_ok_cnt, err_cnt); end
    rst_l = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_frame();
    int hs0 = hs_cnt, v0 = valid_cycles;
    wr_bus.wr_ready = 1'b1;
    send_frame(8'h12, 8'h34, 8'h83);
    exp_ok = exp_ok + 1;
    tick(3);
    total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL basic_handshakes: got %0d expected 1", hs_cnt - hs0); end
    total++; if (valid_cycles - v0 !== 1) begin bad++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cycles - v0); end
    total++; if (pkt_ok_cnt !== exp_ok) begin bad++; $display("FAIL basic_ok_cnt: got %0d expected %0d", pkt_ok_cnt, exp_ok); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL basic_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b expected 0", busy); end
  endtask

  task automatic test_hunt_discard();
    send_byte(8'h00);
    send_byte(8'hFF);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hunt_busy: got %b expected 0", busy); end
    send_frame(8'h01, 8'h02, 8'hA6);
    exp_ok = exp_ok + 1;
    tick(3);
    total++; if (pkt_ok_cnt !== exp_ok) begin bad++; $display("FAIL hunt_ok_cnt: got %0d expected %0d", pkt_ok_cnt, exp_ok); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL hunt_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
  endtask

  task automatic test_bad_csum();
    int hs0 = hs_cnt, p0 = errp_cycles;
    send_frame(8'h01, 8'h02, 8'h00);
    exp_err = exp_err + 1;
    tick(3);
    total++; if (hs_cnt - hs0 !== 0) begin bad++; $display("FAIL csum_handshakes: got %0d expected 0", hs_cnt - hs0); end
    total++; if (errp_cycles - p0 !== 1) begin bad++; $display("FAIL csum_pulse_cycles: got %0d expected 1", errp_cycles - p0); end
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL csum_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL csum_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overrun();
    int hs0 = hs_cnt;
    wr_bus.wr_ready = 1'b0;
    send_frame(8'h33, 8'h44, 8'hA5 ^ 8'h33 ^ 8'h44);
    total++; if ({wr_bus.wr_valid, wr_bus.wr_addr, wr_bus.wr_data} !== {1'b1, 8'h33, 8'h44}) begin bad++; $display("FAIL ovr_pending: got %b %h %h expected 1 33 44", wr_bus.wr_valid, wr_bus.wr_addr, wr_bus.wr_data); end
    send_byte(8'h55);
    exp_err = exp_err + 1;
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL ovr_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    total++; if ({wr_bus.wr_valid, busy, wr_bus.wr_addr, wr_bus.wr_data} !== {2'b11, 8'h33, 8'h44}) begin bad++; $display("FAIL ovr_kept: got %b%b %h %h expected 11 33 44", wr_bus.wr_valid, busy, wr_bus.wr_addr, wr_bus.wr_data); end
    wr_bus.wr_ready = 1'b1;
    exp_ok = exp_ok + 1;
    tick(4);
    total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL ovr_handshakes: got %0d expected 1", hs_cnt - hs0); end
    total++; if (pkt_ok_cnt !== exp_ok) begin bad++; $display("FAIL ovr_ok_cnt: got %0d expected %0d", pkt_ok_cnt, exp_ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    tick(100);
`ifdef UART_CMD_TIMEOUT_EN
    exp_err = exp_err + 1;
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL tmo_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    send_frame(8'h21, 8'h43, 8'hA5 ^ 8'h21 ^ 8'h43);
`else
    total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL notmo_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL notmo_busy: got %b expected 1", busy); end
    begin
      wr_t w;
      w.a = 8'h01; w.d = 8'h21;
      exp_q.push_back(w);
    end
    send_byte(8'h21);
    send_byte(8'hA5 ^ 8'h01 ^ 8'h21);
`endif
    exp_ok = exp_ok + 1;
    tick(3);
    total++; if (pkt_ok_cnt !== exp_ok) begin bad++; $display("FAIL tmo_ok_cnt: got %0d expected %0d", pkt_ok_cnt, exp_ok); end
  endtask

  task automatic test_saturate_and_reset();
    int hs0;
    for (int i = 0; i < 300; i++) send_frame(8'(i), 8'h5A, 8'h00 ^ 8'(i));
    tick(2);
    total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_err_cnt: got %0d expected 255", err_cnt); end
    total++; if (pkt_ok_cnt !== exp_ok) begin bad++; $display("FAIL sat_ok_cnt: got %0d expected %0d", pkt_ok_cnt, exp_ok); end
    send_byte(8'hA5);
    send_byte(8'h01);
    rst_l = 1'b0;
    tick(2);
    total++; if ({wr_bus.wr_valid, busy, err_pulse} !== 3'b000) begin bad++; $display("FAIL midrst_flags: got %b%b%b expected 000", wr_bus.wr_valid, busy, err_pulse); end
    total++; if ({pkt_ok_cnt, err_cnt, wr_bus.wr_addr, wr_bus.wr_data} !== 32'h0) begin bad++; $display("FAIL midrst_values: got %h %h %h %h expected 00 00 00 00", pkt_ok_cnt, err_cnt, wr_bus.wr_addr, wr_bus.wr_data); end
    rst_l = 1'b1;
    tick(2);
    hs0 = hs_cnt;
    send_byte(8'h02);
    send_byte(8'hA6);
    total++; if ({busy, pkt_ok_cnt, err_cnt} !== 17'h0) begin bad++; $display("FAIL midrst_lost: got %b %0d %0d expected 0 0 0", busy, pkt_ok_cnt, err_cnt); end
    send_frame(8'h77, 8'h88, 8'hA5 ^ 8'h77 ^ 8'h88);
    tick(3);
    total++; if (hs_cnt - hs0 !== 1 || pkt_ok_cnt !== 8'd1) begin bad++; $display("FAIL midrst_recover: got hs=%0d ok=%0d expected hs=1 ok=1", hs_cnt - hs0, pkt_ok_cnt); end
  endtask

  initial begin
    wr_bus.wr_ready = 1'b1;
    test_reset();
    test_basic_frame();
    test_hunt_discard();
    test_bad_csum();
    test_overrun();
    test_timeout();
    test_saturate_and_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
